// File: rtl/cmp_config_parser_if.sv
// cmp_config_parser_if: byte-stream, comparator-write and config-read signals of
// cmp_config_parser bundled into one interface.
//   slave  : parser side (cmp_config_parser)
//   master : pkt_comm / bcrypt core side (drives din, wr_en, mode_cmp,
//            cmp_config_applied, addr; observes everything else)
interface cmp_config_parser_if #(
  parameter int unsigned HASH_COUNT_W = 10,
  parameter int unsigned HASH_BYTES   = 4,
  parameter int unsigned ADDR_W       = 4
);
  localparam int unsigned CMP_ADDR_W = HASH_COUNT_W + $clog2(HASH_BYTES);

  logic [7:0]              din;
  logic                    wr_en;
  logic                    full;
  logic                    error;
  logic [2:0]              err_code;
  logic                    mode_cmp;
  logic                    new_cmp_config;
  logic                    cmp_config_applied;
  logic [HASH_COUNT_W-1:0] hash_count;
  logic [CMP_ADDR_W-1:0]   cmp_wr_addr;
  logic                    cmp_wr_en;
  logic [7:0]              cmp_din;
  logic [ADDR_W-1:0]       addr;
  logic [31:0]             dout;
  logic                    active_bank;
  logic                    sign_extension_bug;

  modport master (
    output din, wr_en, mode_cmp, cmp_config_applied, addr,
    input  full, error, err_code, new_cmp_config, hash_count, cmp_wr_addr, cmp_wr_en,
           cmp_din, dout, active_bank, sign_extension_bug
  );

  modport slave (
    input  din, wr_en, mode_cmp, cmp_config_applied, addr,
    output full, error, err_code, new_cmp_config, hash_count, cmp_wr_addr, cmp_wr_en,
           cmp_din, dout, active_bank, sign_extension_bug
  );
endinterface

// File: rtl/cmp_config_parser.sv
// cmp_config_parser: double-buffered bcrypt CMP_CONFIG packet parser.
// Parses salt, [subtype], iteration count, hash count and comparator data from a
// byte stream. Salt and iteration count go to the shadow config bank, which becomes
// active only when the core acknowledges with cmp_config_applied. Comparator bytes
// are streamed out with one cycle of latency. Malformed packets park the parser in
// a sticky error state with a reason code (1 subtype, 2 iteration count,
// 3 hash count, 4 magic).
// Ports:
//   CLK, rst : clock, synchronous active-high reset
//   bus      : cmp_config_parser_if.slave (byte stream in, full, error/err_code,
//              comparator writes out, config bank read port, apply handshake)
// Build option: define CMP_CONFIG_SUBTYPE_EN to expect and check the subtype byte
// after the salt and to drive sign_extension_bug from it; otherwise the packet has
// no subtype byte and sign_extension_bug is tied to 0.
module cmp_config_parser #(
  parameter int unsigned SALT_BYTES   = 16,
  parameter int unsigned HASH_BYTES   = 4,
  parameter int unsigned MAX_HASHES   = 512,
  parameter int unsigned HASH_COUNT_W = 10,
  parameter int unsigned SETTING_MAX  = 18,
  parameter int unsigned ADDR_W       = 4
) (
  input logic               CLK,
  input logic               rst,
  cmp_config_parser_if.slave bus
);

  localparam int unsigned HB_LOG2    = $clog2(HASH_BYTES);
  localparam int unsigned CMP_ADDR_W = HASH_COUNT_W + HB_LOG2;
  localparam int unsigned CNT_W      = $clog2(SALT_BYTES);
  // Bits of the iteration count that must stay clear.
  localparam logic [31:0] ITER_BAD_MASK = ~((32'd1 << (SETTING_MAX + 1)) - 32'd1);

  typedef enum logic [3:0] {
    StSalt,
    StSubtype,
    StIter,
    StHcnt0,
    StHcnt1,
    StCmpData,
    StWaitApplied,
    StMagic,
    StError
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              err_code_q, err_code_d;
  logic [CNT_W-1:0]        byte_cnt_q;
  logic [23:0]             word_q;
  logic [31:0]             word_next;
  logic [7:0]              hcnt_lo_q;
  logic [15:0]             hcnt_word;
  logic [HASH_COUNT_W-1:0] hash_count_q;
  logic [CMP_ADDR_W-1:0]   cmp_wr_addr_q;
  logic [CMP_ADDR_W-1:0]   cmp_last_addr;
  logic                    cmp_wr_en_q;
  logic [7:0]              cmp_din_q;
  logic                    active_bank_q;
  logic                    shadow_bank;
  logic [31:0]             bank_q [2][2**ADDR_W];

  logic              full;
  logic              accept;
  logic              word_done;
  logic              hcnt_ok;
  logic              apply;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;

  assign full      = (state_q == StWaitApplied) || (state_q == StError);
  assign accept    = bus.wr_en && !full;
  // Little-endian packing: the newest byte lands in the top lane.
  assign word_next = {bus.din, word_q};
  assign word_done = (byte_cnt_q[1:0] == 2'd3);
  assign hcnt_word = {bus.din, hcnt_lo_q};
  assign hcnt_ok   = bus.mode_cmp ? ((hcnt_word != 16'd0) && (hcnt_word <= 16'(MAX_HASHES)))
                                  : (hcnt_word == 16'd0);
  assign apply     = (state_q == StWaitApplied) && bus.cmp_config_applied;
  assign cmp_last_addr = (CMP_ADDR_W'(hash_count_q) << HB_LOG2) - CMP_ADDR_W'(1);
  assign shadow_bank   = ~active_bank_q;

  // Next-state and error-code logic.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      StSalt: begin
        if (accept && word_done && (byte_cnt_q == CNT_W'(SALT_BYTES - 1))) begin
`ifdef CMP_CONFIG_SUBTYPE_EN
          state_d = StSubtype;
`else
          state_d = StIter;
`endif
        end
      end
`ifdef CMP_CONFIG_SUBTYPE_EN
      StSubtype: begin
        if (accept) begin
          if (bus.din == "x" || bus.din == "a" || bus.din == "b" || bus.din == "y") begin
            state_d = StIter;
          end else begin
            state_d    = StError;
            err_code_d = 3'd1;
          end
        end
      end
`endif
      StIter: begin
        if (accept && word_done) begin
          if ((word_next & ITER_BAD_MASK) != 32'd0) begin
            state_d    = StError;
            err_code_d = 3'd2;
          end else begin
            state_d = StHcnt0;
          end
        end
      end
      StHcnt0: begin
        if (accept) state_d = StHcnt1;
      end
      StHcnt1: begin
        if (accept) begin
          if (!hcnt_ok) begin
            state_d    = StError;
            err_code_d = 3'd3;
          end else if (bus.mode_cmp) begin
            state_d = StCmpData;
          end else begin
            state_d = StWaitApplied;
          end
        end
      end
      StCmpData: begin
        if (accept && ((cmp_wr_addr_q + CMP_ADDR_W'(1)) == cmp_last_addr)) begin
          state_d = StWaitApplied;
        end
      end
      StWaitApplied: begin
        if (apply) state_d = StMagic;
      end
      StMagic: begin
        if (accept) begin
          if (bus.din == 8'hCC) begin
            state_d = StSalt;
          end else begin
            state_d    = StError;
            err_code_d = 3'd4;
          end
        end
      end
      StError: state_d = StError;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= StSalt;
      err_code_q    <= 3'd0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      hcnt_lo_q     <= 8'd0;
      hash_count_q  <= '0;
      cmp_wr_addr_q <= '1;
      cmp_wr_en_q   <= 1'b0;
      cmp_din_q     <= 8'd0;
      active_bank_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      cmp_wr_en_q <= 1'b0;

      // Byte counter restarts on every state change.
      if (state_d != state_q) begin
        byte_cnt_q <= '0;
      end else if (accept && (state_q == StSalt || state_q == StIter)) begin
        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      end

      if (accept) begin
        word_q <= word_next[31:8];
        if (state_q == StHcnt0) hcnt_lo_q <= bus.din;
        if (state_q == StHcnt1 && hcnt_ok) hash_count_q <= HASH_COUNT_W'(hcnt_word);
        if (state_q == StCmpData) begin
          cmp_wr_addr_q <= cmp_wr_addr_q + CMP_ADDR_W'(1);
          cmp_wr_en_q   <= 1'b1;
          cmp_din_q     <= bus.din;
        end
      end

      // Preset so the first data byte increments to address 0.
      if (state_q == StHcnt1) cmp_wr_addr_q <= '1;

      if (apply) active_bank_q <= ~active_bank_q;
    end
  end

  // Config banks: word 0 = iteration count, words 1.. = salt. Not reset.
  assign bank_we    = accept && word_done && (state_q == StSalt || state_q == StIter);
  assign bank_waddr = (state_q == StIter) ? ADDR_W'(0)
                                          : ADDR_W'(byte_cnt_q >> 2) + ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (bank_we) bank_q[shadow_bank][bank_waddr] <= word_next;
  end

`ifdef CMP_CONFIG_SUBTYPE_EN
  logic sub_pending_q;
  logic sign_ext_q;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sub_pending_q <= 1'b0;
      sign_ext_q    <= 1'b0;
    end else begin
      if (accept && state_q == StSubtype) sub_pending_q <= (bus.din == "x");
      if (apply) sign_ext_q <= sub_pending_q;
    end
  end

  assign bus.sign_extension_bug = sign_ext_q;
`else
  assign bus.sign_extension_bug = 1'b0;
`endif

  assign bus.full           = full;
  assign bus.error          = (state_q == StError);
  assign bus.err_code       = err_code_q;
  assign bus.new_cmp_config = (state_q == StWaitApplied);
  assign bus.hash_count     = hash_count_q;
  assign bus.cmp_wr_addr    = cmp_wr_addr_q;
  assign bus.cmp_wr_en      = cmp_wr_en_q;
  assign bus.cmp_din        = cmp_din_q;
  assign bus.active_bank    = active_bank_q;
  assign bus.dout           = bank_q[active_bank_q][bus.addr];

endmodule

// File: tb/tb_cmp_config_parser.sv
`timescale 1ns/1ps
// Self-checking bench for cmp_config_parser: table-driven packet vectors plus
// hand-written double-buffer and reset-mid-packet sequences; comparator writes are
// checked against a queue of expected {address, byte} pairs.
module tb_cmp_config_parser;
  localparam int unsigned SALT_BYTES   = 16;
  localparam int unsigned HASH_BYTES   = 4;
  localparam int unsigned MAX_HASHES   = 512;
  localparam int unsigned HASH_COUNT_W = 10;
  localparam int unsigned SETTING_MAX  = 18;
  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned CMP_ADDR_W   = HASH_COUNT_W + $clog2(HASH_BYTES);
`ifdef CMP_CONFIG_SUBTYPE_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  cmp_config_parser_if #(
    .HASH_COUNT_W(HASH_COUNT_W),
    .HASH_BYTES  (HASH_BYTES),
    .ADDR_W      (ADDR_W)
  ) bus ();

  cmp_config_parser #(
    .SALT_BYTES  (SALT_BYTES),
    .HASH_BYTES  (HASH_BYTES),
    .MAX_HASHES  (MAX_HASHES),
    .HASH_COUNT_W(HASH_COUNT_W),
    .SETTING_MAX (SETTING_MAX),
    .ADDR_W      (ADDR_W)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic       exp_bank = 1'b0;
  logic [7:0] last_sub = 8'h00;

  typedef struct {
    logic [CMP_ADDR_W-1:0] addr;
    logic [7:0]            data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    string       name;
    logic        mode;
    logic [7:0]  sub;
    logic [31:0] iter;
    int          count;
    logic [2:0]  err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every comparator write must match the oldest expected entry.
  always @(negedge CLK) begin
    if (bus.cmp_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("cmp_wr_en unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("cmp_wr_addr", 32'(bus.cmp_wr_addr), 32'(e.addr));
        check("cmp_din", 32'(bus.cmp_din), 32'(e.data));
      end
    end
  end

  function automatic logic [31:0] salt_word(input logic [7:0] base, input int k);
    logic [7:0] b0, b1, b2, b3;
    b0 = base + 8'(4 * k);
    b1 = b0 + 8'd1;
    b2 = b0 + 8'd2;
    b3 = b0 + 8'd3;
    return {b3, b2, b1, b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.din   = b;
    bus.wr_en = 1'b1;
    @(posedge CLK);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst                    = 1'b1;
    bus.wr_en              = 1'b0;
    bus.cmp_config_applied = 1'b0;
    @(posedge CLK);
    #1;
    rst      = 1'b0;
    exp_bank = 1'b0;
  endtask

  task automatic apply_cfg();
    bus.cmp_config_applied = 1'b1;
    @(posedge CLK);
    #1;
    bus.cmp_config_applied = 1'b0;
    exp_bank = ~exp_bank;
  endtask

  task automatic check_dout(input string name, input int a, input logic [31:0] exp);
    bus.addr = ADDR_W'(a);
    #1;
    check(name, bus.dout, exp);
  endtask

  task automatic send_header(input logic mode, input logic [7:0] salt_base,
                             input logic [7:0] sub, input logic [31:0] iter,
                             input int count);
    logic [15:0] c;
    c            = 16'(count);
    last_sub     = sub;
    bus.mode_cmp = mode;
    for (int k = 0; k < int'(SALT_BYTES); k++) send_byte(salt_base + 8'(k));
    check("new_cmp_config after salt", 32'(bus.new_cmp_config), 32'd0);
`ifdef CMP_CONFIG_SUBTYPE_EN
    send_byte(sub);
`endif
    for (int k = 0; k < 4; k++) send_byte(iter[8*k +: 8]);
    send_byte(c[7:0]);
    send_byte(c[15:8]);
  endtask

  task automatic send_data(input int count, input logic [7:0] base);
    int n;
    n = count * int'(HASH_BYTES);
    for (int k = 0; k < n; k++) begin
      wr_t e;
      if (k == n - 1) check("new_cmp_config before last data", 32'(bus.new_cmp_config), 32'd0);
      e.addr = CMP_ADDR_W'(k);
      e.data = base + 8'(k);
      exp_q.push_back(e);
      send_byte(e.data);
    end
  endtask

  initial begin
    bus.din                = 8'd0;
    bus.wr_en              = 1'b0;
    bus.mode_cmp           = 1'b0;
    bus.cmp_config_applied = 1'b0;
    bus.addr               = '0;

    vecs.push_back('{"cmp_basic",   1'b1, "b", 32'h0000_0400, 2,   3'd0});
    vecs.push_back('{"noncmp_x",    1'b0, "x", 32'h0000_0400, 0,   3'd0});
    vecs.push_back('{"cmp_max",     1'b1, "y", 32'h0007_FFFF, 512, 3'd0});
    vecs.push_back('{"iter_bit19",  1'b1, "a", 32'h0008_0000, 2,   3'd2});
    vecs.push_back('{"cmp_cnt_513", 1'b1, "b", 32'h0000_0010, 513, 3'd3});
    vecs.push_back('{"cmp_cnt_0",   1'b1, "b", 32'h0000_0010, 0,   3'd3});
    vecs.push_back('{"noncmp_cnt1", 1'b0, "b", 32'h0000_0010, 1,   3'd3});
    if (SUB_EN) vecs.push_back('{"bad_subtype", 1'b1, "z", 32'h0000_0010, 1, 3'd1});

    // Reset values.
    do_reset();
    check("rst full",        32'(bus.full), 32'd0);
    check("rst error",       32'(bus.error), 32'd0);
    check("rst err_code",    32'(bus.err_code), 32'd0);
    check("rst new_cfg",     32'(bus.new_cmp_config), 32'd0);
    check("rst hash_count",  32'(bus.hash_count), 32'd0);
    check("rst cmp_wr_addr", 32'(bus.cmp_wr_addr), 32'((1 << CMP_ADDR_W) - 1));
    check("rst cmp_wr_en",   32'(bus.cmp_wr_en), 32'd0);
    check("rst cmp_din",     32'(bus.cmp_din), 32'd0);
    check("rst active_bank", 32'(bus.active_bank), 32'd0);
    check("rst sign_ext",    32'(bus.sign_extension_bug), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t       v;
      logic [7:0] sb;
      v  = vecs[i];
      sb = 8'(i * 16);
      do_reset();
      send_header(v.mode, sb, v.sub, v.iter, v.count);
      if (v.err == 3'd0) begin
        if (v.mode) begin
          send_data(v.count, 8'hA0 + 8'(i));
          check({v.name, " cmp_wr_addr last"}, 32'(bus.cmp_wr_addr),
                32'(v.count * int'(HASH_BYTES) - 1));
        end
        check({v.name, " new_cmp_config"}, 32'(bus.new_cmp_config), 32'd1);
        check({v.name, " full waiting"}, 32'(bus.full), 32'd1);
        check({v.name, " hash_count"}, 32'(bus.hash_count), 32'(v.count));
        apply_cfg();
        check({v.name, " active_bank"}, 32'(bus.active_bank), 32'(exp_bank));
        check({v.name, " new_cmp_config cleared"}, 32'(bus.new_cmp_config), 32'd0);
        check({v.name, " full cleared"}, 32'(bus.full), 32'd0);
        check({v.name, " sign_ext"}, 32'(bus.sign_extension_bug),
              32'(SUB_EN && (last_sub == "x")));
        check_dout({v.name, " dout iter"}, 0, v.iter);
        check_dout({v.name, " dout salt0"}, 1, salt_word(sb, 0));
        check_dout({v.name, " dout salt3"}, int'(SALT_BYTES / 4), salt_word(sb, 3));
        send_byte(8'hCC);
        check({v.name, " error after magic"}, 32'(bus.error), 32'd0);
        check({v.name, " full after magic"}, 32'(bus.full), 32'd0);
      end else begin
        repeat (3) send_byte(8'h55);
        check({v.name, " error"}, 32'(bus.error), 32'd1);
        check({v.name, " err_code"}, 32'(bus.err_code), 32'(v.err));
        check({v.name, " full"}, 32'(bus.full), 32'd1);
        check({v.name, " new_cmp_config"}, 32'(bus.new_cmp_config), 32'd0);
        check({v.name, " hash_count"}, 32'(bus.hash_count), 32'd0);
      end
    end

    // Double buffering: second config streamed while bank 1 is read, then bad magic.
    do_reset();
    send_header(1'b0, 8'h00, "b", 32'h0000_0400, 0);
    apply_cfg();
    send_byte(8'hCC);
    send_header(1'b0, 8'h40, "a", 32'h0000_0123, 0);
    check("dbuf active_bank held", 32'(bus.active_bank), 32'd1);
    check_dout("dbuf dout0 held", 0, 32'h0000_0400);
    check_dout("dbuf dout1 held", 1, 32'h0302_0100);
    repeat (5) @(posedge CLK);
    #1;
    check("dbuf new_cmp_config waiting", 32'(bus.new_cmp_config), 32'd1);
    check_dout("dbuf dout1 still held", 1, 32'h0302_0100);
    apply_cfg();
    check("dbuf active_bank", 32'(bus.active_bank), 32'd0);
    check_dout("dbuf dout0 new", 0, 32'h0000_0123);
    check_dout("dbuf dout1 new", 1, 32'h4342_4140);
    send_byte(8'h00);
    check("bad magic error", 32'(bus.error), 32'd1);
    check("bad magic err_code", 32'(bus.err_code), 32'd4);
    check("bad magic full", 32'(bus.full), 32'd1);

    // Reset in the middle of comparator data, then a clean packet.
    do_reset();
    send_header(1'b1, 8'h10, "b", 32'h0000_0055, 2);
    for (int k = 0; k < 3; k++) begin
      wr_t e;
      e.addr = CMP_ADDR_W'(k);
      e.data = 8'h70 + 8'(k);
      exp_q.push_back(e);
      send_byte(e.data);
    end
    do_reset();
    check("midrst full", 32'(bus.full), 32'd0);
    check("midrst cmp_wr_addr", 32'(bus.cmp_wr_addr), 32'((1 << CMP_ADDR_W) - 1));
    check("midrst active_bank", 32'(bus.active_bank), 32'd0);
    check("midrst hash_count", 32'(bus.hash_count), 32'd0);
    check("midrst new_cmp_config", 32'(bus.new_cmp_config), 32'd0);
    // Apply outside WAIT_APPLIED must be ignored.
    bus.cmp_config_applied = 1'b1;
    @(posedge CLK);
    #1;
    bus.cmp_config_applied = 1'b0;
    check("stray apply active_bank", 32'(bus.active_bank), 32'd0);
    send_header(1'b1, 8'h20, "b", 32'h0000_0400, 2);
    send_data(2, 8'hE0);
    check("fresh new_cmp_config", 32'(bus.new_cmp_config), 32'd1);
    apply_cfg();
    check("fresh active_bank", 32'(bus.active_bank), 32'(exp_bank));
    check_dout("fresh dout0", 0, 32'h0000_0400);
    check_dout("fresh dout1", 1, 32'h2322_2120);
    send_byte(8'hCC);
    check("fresh full after magic", 32'(bus.full), 32'd0);

    repeat (2) @(posedge CLK);
    #1;
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
